// File: rtl/dna_pkg.sv
// Shared types and constants for the DNA digit compaction path.
package dna_pkg;

   localparam int unsigned DIGIT_W = 2;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   // Digits 95..65, 61..17 and 13..6 of the original 100-digit word (84 kept)
   localparam logic [99:0] LEGACY_KEEP_MASK = 100'h0FFFFFFFE3FFFFFFFFFFE3FC0;

endpackage

// File: rtl/dna_lane_compact.sv
// Combinational lane compactor: packs the kept digits of one scan group MSB-first
// and reports how many were kept.
module dna_lane_compact
   import dna_pkg::*;
#(
   parameter int unsigned LANES = 4,
   localparam int unsigned CW = $clog2(LANES + 1)
) (
   input  digit_t [LANES-1:0] digits,
   input  logic   [LANES-1:0] keep,
   output digit_t [LANES-1:0] kept,
   output logic   [CW-1:0]    count
);

   localparam int unsigned GW = DIGIT_W * LANES;

   logic [GW-1:0] packed_low;
   logic [CW-1:0] n;
   int unsigned   sh;

   // Collect kept digits at the low end (first kept highest), then left-justify
   always_comb begin
      packed_low = '0;
      n          = '0;
      for (int j = LANES - 1; j >= 0; j--) begin
         if (keep[j]) begin
            packed_low = (packed_low << DIGIT_W) | GW'(digits[j]);
            n          = n + CW'(1);
         end
      end
      sh    = DIGIT_W * (LANES - 32'(n));
      kept  = packed_low << sh;
      count = n;
   end

endmodule

// File: rtl/dna_digit_compactor.sv
// Sequential DNA digit compactor, LANES digits per scan cycle, valid/ready on both sides.
// DNA_COMPACT_FIXED_MASK_EN: ignore keep_mask and use dna_pkg::LEGACY_KEEP_MASK (N=100, M=84 only).
module dna_digit_compactor
   import dna_pkg::*;
#(
   parameter int unsigned N     = 100,
   parameter int unsigned M     = 84,
   parameter int unsigned LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*N-1:0]     word_in,
   input  logic [N-1:0]       keep_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*M-1:0]     word_out,
   output logic               count_err
);

   localparam int unsigned G   = (N + LANES - 1) / LANES;
   localparam int unsigned NP  = G * LANES;
   localparam int unsigned PAD = NP - N;
   localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned CW  = $clog2(LANES + 1);
   localparam int unsigned KW  = $clog2(M + 2);
   localparam int unsigned SW  = ((KW > CW) ? KW : CW) + 1;

   state_t                      state;
   logic [GW-1:0]               grp;
   logic [DIGIT_W*NP-1:0]       word_q;
   logic [NP-1:0]               mask_q;
   logic [DIGIT_W*M-1:0]        acc;
   logic [KW-1:0]               kcnt;

   logic [N-1:0]                mask_src;
   digit_t [LANES-1:0]          lane_digits;
   logic   [LANES-1:0]          lane_keep;
   digit_t [LANES-1:0]          lane_kept;
   logic   [CW-1:0]             lane_cnt;

   logic [DIGIT_W*(M+LANES)-1:0] ext;
   logic [DIGIT_W*M-1:0]         acc_next;
   logic [SW-1:0]                ksum;
   logic [KW-1:0]                kcnt_next;

`ifdef DNA_COMPACT_FIXED_MASK_EN
   if (N != 100 || M != 84) begin : g_cfg_check
      $error("DNA_COMPACT_FIXED_MASK_EN requires N=100 and M=84");
   end
   assign mask_src = N'(LEGACY_KEEP_MASK);
`else
   assign mask_src = keep_mask;
`endif

   // Current group is always the top LANES digits of the left-shifting capture registers
   assign lane_digits = word_q[DIGIT_W*NP-1 -: DIGIT_W*LANES];
   assign lane_keep   = mask_q[NP-1 -: LANES];

   dna_lane_compact #(
      .LANES (LANES)
   ) u_lane (
      .digits (lane_digits),
      .keep   (lane_keep),
      .kept   (lane_kept),
      .count  (lane_cnt)
   );

   // Drop the packed group in just below the digits already filled; overflow falls off the bottom
   always_comb begin
      ext       = {lane_kept, {(DIGIT_W*M){1'b0}}};
      ext       = ext >> (DIGIT_W * (LANES + 32'(kcnt)));
      acc_next  = acc | ext[DIGIT_W*M-1:0];
      ksum      = SW'(kcnt) + SW'(lane_cnt);
      kcnt_next = (ksum > SW'(M + 1)) ? KW'(M + 1) : KW'(ksum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grp       <= '0;
         word_q    <= '0;
         mask_q    <= '0;
         acc       <= '0;
         kcnt      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         word_out  <= '0;
         count_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // Pad below digit 0 with unkept lanes so the tail group needs no special case
                  word_q   <= (DIGIT_W*NP)'(word_in) << (DIGIT_W * PAD);
                  mask_q   <= NP'(mask_src) << PAD;
                  acc      <= '0;
                  kcnt     <= '0;
                  grp      <= '0;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               word_q <= word_q << (DIGIT_W * LANES);
               mask_q <= mask_q << LANES;
               acc    <= acc_next;
               kcnt   <= kcnt_next;
               grp    <= grp + GW'(1);
               if (grp == GW'(G - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  word_out  <= acc;
                  count_err <= (kcnt != KW'(M));
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
